// File: rtl/timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timing_pkg
//  Description : Shared beat and sequencer-state encodings for the machine
//                cycle timing logic.
//  Revision    : 1.0  initial release
// ============================================================================
package timing_pkg;

    // Beat encoding: bit 0 distinguishes action beats from scan beats
    typedef enum logic [1:0] {
        BEAT_S1 = 2'd0,
        BEAT_A1 = 2'd1,
        BEAT_S2 = 2'd2,
        BEAT_A2 = 2'd3
    } beat_t;

    // Sequencer run-control states
    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_SINGLE  = 2'd2,
        ST_FINISH  = 2'd3
    } seq_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;

    // Action beats are A1 and A2, i.e. the odd encodings
    function automatic logic beat_is_action(input beat_t b);
        return b[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : switch_sync_edge
//  Description : Multi-flop synchroniser for an asynchronous operator switch
//                with a registered rising-edge detector on the synced level.
//  Revision    : 1.0  initial release
// ============================================================================
module switch_sync_edge
    import timing_pkg::*;
#(
    parameter int   STAGES    = DEF_SYNC_STAGES,
    // Value loaded into the chain during reset. Loading 1 makes a switch
    // that is already held when reset releases look "already pressed", so
    // no rising edge is reported for it.
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              level_d;

    // Shift the raw input through the synchroniser and remember the last level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {STAGES{RESET_VAL}};
            level_d <= RESET_VAL;
        end else begin
            sync_q  <= (sync_q << 1) | STAGES'(async_in);
            level_d <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~level_d;

endmodule
`default_nettype wire

// File: rtl/beat_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : beat_sequencer
//  Description : Steps the machine cycle through S1, A1, S2, A2 on prepulse
//                beat markers under RUN/STOP and single-shot control, and
//                emits registered per-beat entry strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module beat_sequencer
    import timing_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prepulse,
    input  logic             run_sw,
    input  logic             ksc_btn,
    input  logic             stop_instr,
    output logic [1:0]       beat,
    output logic             scan,
    output logic             action,
    output logic             ci_inc,
    output logic             instr_fetch,
    output logic             decode,
    output logic             execute,
    output logic             action_trigger,
    output logic             stopped,
    output logic [CNT_W-1:0] instr_count
);

    logic run_sw_s;
    logic run_rise_unused;
    logic ksc_level_unused;
    logic ksc_rise;

    // RUN switch: only the synchronised level matters
    switch_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_run_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (run_sw),
        .level    (run_sw_s),
        .rise     (run_rise_unused)
    );

    // KSC button: reset to "pressed" so a button held through reset never
    // produces a single shot when reset releases
    switch_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_ksc_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ksc_btn),
        .level    (ksc_level_unused),
        .rise     (ksc_rise)
    );

    seq_state_t       state_q, state_d;
    seq_state_t       eff_state;
    beat_t            beat_q, beat_d;
    logic             fresh_q, fresh_d;      // waiting for first prepulse after start
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       strobe_q, strobe_d;    // bit k = entry to beat k

    // Sequencer state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_STOPPED;
            beat_q   <= BEAT_S1;
            fresh_q  <= 1'b0;
            count_q  <= '0;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            fresh_q  <= fresh_d;
            count_q  <= count_d;
            strobe_q <= strobe_d;
        end
    end

    // Next-state: run control, beat advance, cycle end and strobe generation
    always_comb begin
        state_d   = state_q;
        eff_state = state_q;
        beat_d    = beat_q;
        fresh_d   = fresh_q;
        count_d   = count_q;
        strobe_d  = '0;

        unique case (state_q)
            ST_STOPPED: begin
                beat_d  = BEAT_S1;
                fresh_d = 1'b0;
                if (run_sw_s) begin
                    state_d = ST_RUN;
                    fresh_d = 1'b1;
                end else if (ksc_rise) begin
                    state_d = ST_SINGLE;
                    fresh_d = 1'b1;
                end
            end

            default: begin
                // The switch only decides whether the cycle in progress is
                // the last one; it never cuts a cycle short.
                if (state_q == ST_RUN && !run_sw_s) begin
                    eff_state = ST_FINISH;
                end else if (state_q == ST_FINISH && run_sw_s) begin
                    eff_state = ST_RUN;
                end
                state_d = eff_state;

                if (prepulse) begin
                    if (fresh_q) begin
                        // First beat after starting is the entry to S1
                        fresh_d           = 1'b0;
                        beat_d            = BEAT_S1;
                        strobe_d[BEAT_S1] = 1'b1;
                    end else if (beat_q == BEAT_A2) begin
                        count_d = count_q + CNT_W'(1);
                        beat_d  = BEAT_S1;
                        if (stop_instr || eff_state != ST_RUN) begin
                            state_d = ST_STOPPED;
                        end else begin
                            strobe_d[BEAT_S1] = 1'b1;
                        end
                    end else begin
                        beat_d           = beat_t'(beat_q + 2'd1);
                        strobe_d[beat_d] = 1'b1;
                    end
                end
            end
        endcase
    end

    logic running;
    assign running = (state_q != ST_STOPPED);

    assign beat           = beat_q;
    assign stopped        = ~running;
    assign scan           = running & ~beat_is_action(beat_q);
    assign action         = running &  beat_is_action(beat_q);
    assign ci_inc         = strobe_q[BEAT_S1];
    assign instr_fetch    = strobe_q[BEAT_A1];
    assign decode         = strobe_q[BEAT_S2];
    assign execute        = strobe_q[BEAT_A2];
    assign action_trigger = strobe_q[BEAT_A1] | strobe_q[BEAT_A2];
    assign instr_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_beat_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_beat_sequencer
//  Description : Scoreboard bench for beat_sequencer (CNT_W = 4 build).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_beat_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          prepulse;
    logic          run_sw;
    logic          ksc_btn;
    logic          stop_instr;
    logic [1:0]    beat;
    logic          scan, action;
    logic          ci_inc, instr_fetch, decode, execute, action_trigger;
    logic          stopped;
    logic [CW-1:0] instr_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [12:0] sb_q[$];
    logic [12:0] exp_pop;
    logic [12:0] obs;

    always #5 clk = ~clk;

    beat_sequencer #(
        .SYNC_STAGES (2),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .prepulse       (prepulse),
        .run_sw         (run_sw),
        .ksc_btn        (ksc_btn),
        .stop_instr     (stop_instr),
        .beat           (beat),
        .scan           (scan),
        .action         (action),
        .ci_inc         (ci_inc),
        .instr_fetch    (instr_fetch),
        .decode         (decode),
        .execute        (execute),
        .action_trigger (action_trigger),
        .stopped        (stopped),
        .instr_count    (instr_count)
    );

    assign obs = {ci_inc, instr_fetch, decode, execute, action_trigger,
                  scan, action, beat, instr_count};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected observation for a strobe entering beat 'kind' with count 'cnt'
    function automatic logic [12:0] exp_vec(input int kind, input int cnt);
        logic [3:0] st;
        logic [1:0] b;
        logic       trig;
        logic       sc;
        b    = kind[1:0];
        st   = 4'b1000 >> kind;
        trig = (kind == 1) || (kind == 3);
        sc   = (kind == 0) || (kind == 2);
        return {st, trig, sc, ~sc, b, cnt[3:0]};
    endfunction

    // Scoreboard: every strobe seen must match the oldest pending expectation
    always @(negedge clk) begin
        if (ci_inc | instr_fetch | decode | execute) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_strobe", 32'(obs), 32'd0);
            end else begin
                exp_pop = sb_q.pop_front();
                check_val("strobe", 32'(obs), 32'(exp_pop));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Two idle cycles then one prepulse; returns 1 time unit after the
    // edge that samples it
    task automatic pulse();
        repeat (2) @(posedge clk);
        #1 prepulse = 1'b1;
        @(posedge clk);
        #1 prepulse = 1'b0;
    endtask

    task automatic pp_exp(input int kind, input int cnt);
        sb_q.push_back(exp_vec(kind, cnt));
        pulse();
    endtask

    task automatic check_idle(input string tag, input int cnt);
        check_val({tag, "_stopped"}, 32'(stopped), 32'd1);
        check_val({tag, "_beat"}, 32'(beat), 32'd0);
        check_val({tag, "_count"}, 32'(instr_count), 32'(cnt));
    endtask

    initial begin
        rst        = 1'b1;
        prepulse   = 1'b0;
        run_sw     = 1'b0;
        ksc_btn    = 1'b0;
        stop_instr = 1'b0;
        tick(3);

        // Reset state
        check_val("rst_all", 32'(obs), 32'd0);
        check_val("rst_stopped", 32'(stopped), 32'd1);
        rst = 1'b0;
        tick(2);
        check_idle("post_rst", 0);

        // Free run: two full cycles, then drop the switch during A2
        run_sw = 1'b1;
        tick(6);
        check_val("run_stopped", 32'(stopped), 32'd0);
        for (int j = 0; j < 8; j++) pp_exp(j % 4, j / 4);
        run_sw = 1'b0;
        tick(6);
        check_val("finish_stopped", 32'(stopped), 32'd0);
        pulse();
        check_idle("run_end", 2);
        check_val("run_pending", 32'(sb_q.size()), 32'd0);

        // Single shot: one cycle, then later prepulses do nothing
        ksc_btn = 1'b1;
        tick(4);
        ksc_btn = 1'b0;
        tick(4);
        check_val("ksc_stopped", 32'(stopped), 32'd0);
        for (int k = 0; k < 4; k++) pp_exp(k, 2);
        pulse();
        check_idle("ksc_end", 3);
        pulse();
        check_idle("ksc_extra", 3);
        check_val("ksc_pending", 32'(sb_q.size()), 32'd0);

        // Switch dropped during A1: cycle still completes
        run_sw = 1'b1;
        tick(6);
        pp_exp(0, 3);
        pp_exp(1, 3);
        run_sw = 1'b0;
        tick(6);
        check_val("a1drop_running", 32'(stopped), 32'd0);
        pp_exp(2, 3);
        pp_exp(3, 3);
        pulse();
        check_idle("a1drop_end", 4);
        pulse();
        check_val("a1drop_pending", 32'(sb_q.size()), 32'd0);

        // STP instruction: ignored in S1/A1/S2, halts at end of A2
        run_sw = 1'b1;
        tick(6);
        pp_exp(0, 4);
        stop_instr = 1'b1;
        pp_exp(1, 4);
        pp_exp(2, 4);
        pp_exp(3, 4);
        pulse();
        check_idle("stp_halt", 5);
        stop_instr = 1'b0;
        tick(1);
        check_val("stp_rerun", 32'(stopped), 32'd0);
        for (int k = 0; k < 4; k++) pp_exp(k, 5);
        run_sw = 1'b0;
        tick(6);
        pulse();
        check_idle("stp_end", 6);
        check_val("stp_pending", 32'(sb_q.size()), 32'd0);

        // Counter wrap 15 -> 0, ending in S2 while running
        run_sw = 1'b1;
        tick(6);
        for (int j = 0; j < 67; j++) begin
            pp_exp(j % 4, (6 + j / 4) % 16);
            if (j == 43) check_val("wrap_count", 32'(instr_count), 32'd0);
        end
        check_val("pre_rst_beat", 32'(beat), 32'd2);

        // Reset mid-cycle with KSC held across it
        ksc_btn = 1'b1;
        rst     = 1'b1;
        run_sw  = 1'b0;
        tick(1);
        check_val("midrst_all", 32'(obs), 32'd0);
        check_val("midrst_stopped", 32'(stopped), 32'd1);
        tick(2);
        rst = 1'b0;
        tick(10);
        check_val("ksc_held_stopped", 32'(stopped), 32'd1);
        pulse();
        check_idle("ksc_held_pp", 0);
        ksc_btn = 1'b0;
        tick(4);
        check_val("ksc_release_stopped", 32'(stopped), 32'd1);
        check_val("final_pending", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
